// File: rtl/unidade_busca_pc_if.sv
`default_nettype none
// ============================================================================
//  Module   : unidade_busca_pc_if
//  Brief    : Control/ROM-side bundle of the PC and instruction-fetch stage.
//  Revision : 1.0  initial release
// ============================================================================
interface unidade_busca_pc_if #(
    parameter int LARG = 16
);
    // Requests from control and ALU
    logic            controlePC;
    logic            controlePCcopia;
    logic [3:0]      condicaoJump;
    logic            jump_ver_fal;
    logic [LARG-1:0] salto_destino;
    logic [4:0]      atualizaFlag;
    logic [3:0]      flag_in;

    // Instruction ROM port
    logic [LARG-1:0] rom_dado;
    logic            rom_valido;
    logic [LARG-1:0] rom_addr;
    logic            Rom_sink_cen;
    logic            Rom_sink_ren;

    // Status presented to control
    logic [LARG-1:0] instrucao;
    logic            instr_valida;
    logic [LARG-1:0] pc_atual;
    logic [LARG-1:0] pc_link;
    logic [3:0]      flags;
    logic            ocupado;
    logic            erro_sobreposicao;

    modport master (
        output controlePC, controlePCcopia, condicaoJump, jump_ver_fal,
               salto_destino, atualizaFlag, flag_in, rom_dado, rom_valido,
        input  rom_addr, Rom_sink_cen, Rom_sink_ren, instrucao, instr_valida,
               pc_atual, pc_link, flags, ocupado, erro_sobreposicao
    );

    modport slave (
        input  controlePC, controlePCcopia, condicaoJump, jump_ver_fal,
               salto_destino, atualizaFlag, flag_in, rom_dado, rom_valido,
        output rom_addr, Rom_sink_cen, Rom_sink_ren, instrucao, instr_valida,
               pc_atual, pc_link, flags, ocupado, erro_sobreposicao
    );
endinterface
`default_nettype wire

// File: rtl/unidade_busca_pc.sv
`default_nettype none
// ============================================================================
//  Module   : unidade_busca_pc
//  Brief    : PC, flag and link registers plus ROM fetch FSM with retry.
//  Revision : 1.0  initial release
// ============================================================================
module unidade_busca_pc #(
    parameter int              LARG       = 16,
    parameter int              TIMEOUT    = 8,
    parameter logic [LARG-1:0] PC_INICIAL = '0
) (
    input  logic               clock,
    input  logic               reset,
    unidade_busca_pc_if.slave  bus
);

    localparam int               c_CNT_W   = $clog2(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       c_SEM_JUMP = 4'b1111;
    localparam logic [4:0]       c_SEM_FLAG = 5'b11111;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        REQ    = 2'd1,
        ESPERA = 2'd2
    } estado_t;

    estado_t             r_estado;
    estado_t             w_prox_estado;

    logic [LARG-1:0]     r_pc;
    logic [LARG-1:0]     r_link;
    logic [LARG-1:0]     r_alvo;
    logic [LARG-1:0]     r_instrucao;
    logic [3:0]          r_flags;
    logic                r_salto_pendente;
    logic                r_instr_valida;
    logic                r_erro;
    logic [c_CNT_W-1:0]  r_espera;

    logic                w_avanca;
    logic                w_sobreposicao;
    logic                w_avaliacao;
    logic                w_incondicional;
    logic                w_condicional;
    logic                w_cond;
    logic                w_tomado;
    logic [LARG-1:0]     w_pc_mais_um;

    assign w_pc_mais_um = r_pc + LARG'(1);

    // ------------------------------------------------------------------
    // Jump condition decode against the registered (pre-update) flags
    // ------------------------------------------------------------------
    assign w_avaliacao = (bus.condicaoJump != c_SEM_JUMP);

    always_comb begin
        w_incondicional = 1'b0;
        w_condicional   = 1'b0;
        w_cond          = 1'b0;
        case (bus.condicaoJump)
            4'b0000, 4'b1100: w_incondicional = 1'b1;
            4'b0001: begin w_condicional = 1'b1; w_cond = r_flags[3];               end
            4'b0010: begin w_condicional = 1'b1; w_cond = r_flags[2];               end
            4'b0011: begin w_condicional = 1'b1; w_cond = r_flags[1];               end
            4'b0100: begin w_condicional = 1'b1; w_cond = r_flags[0];               end
            4'b0101: begin w_condicional = 1'b1; w_cond = r_flags[3] | r_flags[2];  end
            4'b0110: begin w_condicional = 1'b1; w_cond = r_flags[3] ^ r_flags[0];  end
            default: begin w_condicional = 1'b0; w_cond = 1'b0;                     end
        endcase
        w_tomado = w_incondicional | (w_condicional & (w_cond == bus.jump_ver_fal));
    end

    // ------------------------------------------------------------------
    // Fetch FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_prox_estado  = r_estado;
        w_avanca       = 1'b0;
        w_sobreposicao = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (bus.controlePC) begin
                    w_avanca      = 1'b1;
                    w_prox_estado = REQ;
                end
            end
            REQ: begin
                w_prox_estado = ESPERA;
            end
            ESPERA: begin
                if (bus.rom_valido) begin
                    w_prox_estado = OCIOSO;
                end else if (r_espera == c_CNT_MAX) begin
                    w_prox_estado = REQ;
                end
            end
            default: begin
                w_prox_estado = OCIOSO;
            end
        endcase
        w_sobreposicao = bus.controlePC && (r_estado != OCIOSO);
    end

    // Reset lands in REQ so the word at PC_INICIAL is fetched without a strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= REQ;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    // ------------------------------------------------------------------
    // PC, jump bookkeeping, link and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc             <= PC_INICIAL;
            r_link           <= '0;
            r_alvo           <= '0;
            r_flags          <= '0;
            r_salto_pendente <= 1'b0;
            r_erro           <= 1'b0;
        end else begin
            if (w_avanca) begin
                r_pc <= r_salto_pendente ? r_alvo : w_pc_mais_um;
            end
            // A fresh evaluation wins over the clear done by an advance
            if (w_avaliacao) begin
                r_salto_pendente <= w_tomado;
                r_alvo           <= bus.salto_destino;
            end else if (w_avanca) begin
                r_salto_pendente <= 1'b0;
            end
            if (bus.controlePCcopia) begin
                r_link <= w_pc_mais_um;
            end
            if (bus.atualizaFlag != c_SEM_FLAG) begin
                r_flags <= bus.flag_in;
            end
            if (w_sobreposicao) begin
                r_erro <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Instruction latch and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_instrucao    <= '0;
            r_instr_valida <= 1'b0;
            r_espera       <= '0;
        end else begin
            case (r_estado)
                REQ: begin
                    r_instr_valida <= 1'b0;
                    r_espera       <= '0;
                end
                ESPERA: begin
                    if (bus.rom_valido) begin
                        r_instrucao    <= bus.rom_dado;
                        r_instr_valida <= 1'b1;
                    end else if (r_espera != c_CNT_MAX) begin
                        r_espera <= r_espera + c_CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Request strobes are gated so they stay low while reset is held in REQ
    assign bus.Rom_sink_cen      = (r_estado == REQ) && !reset;
    assign bus.Rom_sink_ren      = (r_estado == REQ) && !reset;
    assign bus.rom_addr          = r_pc;
    assign bus.instrucao         = r_instrucao;
    assign bus.instr_valida      = r_instr_valida;
    assign bus.pc_atual          = r_pc;
    assign bus.pc_link           = r_link;
    assign bus.flags             = r_flags;
    assign bus.ocupado           = (r_estado != OCIOSO);
    assign bus.erro_sobreposicao = r_erro;

endmodule
`default_nettype wire

// File: tb/tb_unidade_busca_pc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_unidade_busca_pc
//  Brief    : Randomized self-checking bench with a ROM responder and model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_unidade_busca_pc;

    localparam int          LARG       = 16;
    localparam int          TIMEOUT    = 8;
    localparam logic [15:0] PC_INICIAL = 16'h0000;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    unidade_busca_pc_if #(.LARG(LARG)) bus ();

    unidade_busca_pc #(
        .LARG       (LARG),
        .TIMEOUT    (TIMEOUT),
        .PC_INICIAL (PC_INICIAL)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic verifica(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
        total++;
        if (obtido !== esperado) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, obtido, esperado);
        end
    endtask

    // Reference model state
    logic [15:0] m_pc, m_link, m_alvo;
    logic [3:0]  m_flags;
    bit          m_pend, m_erro, em_busca;

    // ROM responder bookkeeping
    int          atrasos[$];
    int          n_req, n_timeouts, rom_cnt, gap;
    bit          rom_ativo, retry_pend;
    logic [15:0] rom_end;

    function automatic logic [15:0] rom_word(input logic [15:0] a);
        logic [15:0] r;
        r = (a * 16'h03B1) ^ 16'hA5A5;
        return r;
    endfunction

    function automatic bit salto_tomado(input logic [3:0] cond, input bit sentido, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'd0, 4'd12: return 1'b1;
            4'd1: return n == sentido;
            4'd2: return z == sentido;
            4'd3: return c == sentido;
            4'd4: return v == sentido;
            4'd5: return (n | z) == sentido;
            4'd6: return (n ^ v) == sentido;
            default: return 1'b0;
        endcase
    endfunction

    task automatic modelo_reset();
        m_pc = PC_INICIAL; m_link = '0; m_alvo = '0; m_flags = '0;
        m_pend = 1'b0; m_erro = 1'b0;
    endtask

    task automatic entradas_ociosas();
        bus.controlePC = 1'b0; bus.controlePCcopia = 1'b0;
        bus.condicaoJump = 4'hF; bus.jump_ver_fal = 1'b0;
        bus.salto_destino = '0; bus.atualizaFlag = 5'h1F; bus.flag_in = '0;
    endtask

    // Drive one cycle of control inputs and advance the model accordingly
    task automatic ciclo(input bit strobe, input bit copia, input logic [3:0] cond,
                         input bit sentido, input logic [15:0] alvo,
                         input logic [4:0] upd, input logic [3:0] fin);
        bit tomado;
        bus.controlePC = strobe; bus.controlePCcopia = copia;
        bus.condicaoJump = cond; bus.jump_ver_fal = sentido;
        bus.salto_destino = alvo; bus.atualizaFlag = upd; bus.flag_in = fin;
        tomado = salto_tomado(cond, sentido, m_flags);
        if (copia) m_link = m_pc + 16'd1;
        if (strobe) begin
            if (em_busca) begin
                m_erro = 1'b1;
            end else begin
                m_pc = m_pend ? m_alvo : m_pc + 16'd1;
                m_pend = 1'b0;
                em_busca = 1'b1;
                n_req = 0; n_timeouts = 0;
            end
        end
        if (cond != 4'hF) begin m_pend = tomado; m_alvo = alvo; end
        if (upd != 5'h1F) m_flags = fin;
        @(negedge clock);
        entradas_ociosas();
    endtask

    task automatic confere_estado(input string tag);
        verifica({tag, "_pc"},    32'(bus.pc_atual), 32'(m_pc));
        verifica({tag, "_link"},  32'(bus.pc_link), 32'(m_link));
        verifica({tag, "_flags"}, 32'(bus.flags), 32'(m_flags));
        verifica({tag, "_erro"},  32'(bus.erro_sobreposicao), 32'(m_erro));
    endtask

    task automatic aguarda_fim(input string tag);
        int k = 0;
        while (bus.ocupado && k < 300) begin
            @(negedge clock);
            k++;
        end
        verifica({tag, "_timeout"}, 32'(bus.ocupado), 32'd0);
        em_busca = 1'b0;
        verifica({tag, "_instr"},  32'(bus.instrucao), 32'(rom_word(m_pc)));
        verifica({tag, "_valida"}, 32'(bus.instr_valida), 32'd1);
        verifica({tag, "_nreq"},   32'(n_req), 32'(1 + n_timeouts));
        confere_estado(tag);
    endtask

    // ROM responder: answers each request after a chosen number of wait cycles
    initial begin
        int d;
        bus.rom_valido = 1'b0; bus.rom_dado = '0;
        rom_ativo = 1'b0; retry_pend = 1'b0; gap = 0; rom_cnt = 0; rom_end = '0;
        forever begin
            @(negedge clock);
            #1;
            bus.rom_valido = 1'b0;
            gap++;
            if (reset) begin
                rom_ativo = 1'b0; retry_pend = 1'b0;
            end else begin
                if (rom_ativo) begin
                    if (rom_cnt == 0) begin
                        bus.rom_valido = 1'b1;
                        bus.rom_dado = rom_word(rom_end);
                        rom_ativo = 1'b0;
                    end else begin
                        rom_cnt--;
                    end
                end
                if (bus.Rom_sink_cen && bus.Rom_sink_ren) begin
                    n_req++;
                    verifica("rom_addr", 32'(bus.rom_addr), 32'(m_pc));
                    if (retry_pend) verifica("retry_gap", 32'(gap), 32'(TIMEOUT + 1));
                    gap = 0;
                    rom_end = bus.rom_addr;
                    d = (atrasos.size() > 0) ? atrasos.pop_front() : int'($urandom_range(0, 10));
                    if (d < TIMEOUT) begin
                        rom_ativo = 1'b1; rom_cnt = d; retry_pend = 1'b0;
                    end else begin
                        rom_ativo = 1'b0; retry_pend = 1'b1; n_timeouts++;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  r_cond, r_fin;
        logic [4:0]  r_upd;
        logic [15:0] r_alvo;
        bit          r_sent, r_copia;

        reset = 1'b1; entradas_ociosas(); modelo_reset();
        em_busca = 1'b0; n_req = 0; n_timeouts = 0;
        repeat (3) @(negedge clock);

        // Reset state
        verifica("rst_pc",     32'(bus.pc_atual), 32'(PC_INICIAL));
        verifica("rst_valida", 32'(bus.instr_valida), 32'd0);
        verifica("rst_cen",    32'(bus.Rom_sink_cen), 32'd0);
        verifica("rst_ren",    32'(bus.Rom_sink_ren), 32'd0);
        verifica("rst_ocup",   32'(bus.ocupado), 32'd1);
        confere_estado("rst");

        // 1: automatic fetch of address 0, ROM answers 2 cycles after request
        atrasos.push_back(1);
        reset = 1'b0; em_busca = 1'b1; n_req = 0; n_timeouts = 0;
        @(negedge clock);
        aguarda_fim("t1");
        verifica("t1_a5a5", 32'(bus.instrucao), 32'h0000_A5A5);

        // 2: plain advance from 0x0003, zero-wait ROM latency
        ciclo(0, 0, 4'h0, 0, 16'h0003, 5'h1F, 4'h0);
        ciclo(1, 0, 4'hF, 0, 16'h0000, 5'h1F, 4'h0);
        aguarda_fim("t2a");
        atrasos.push_back(0);
        ciclo(1, 0, 4'hF, 0, 16'h0000, 5'h1F, 4'h0);
        verifica("t2_addr", 32'(bus.rom_addr), 32'h0000_0004);
        verifica("t2_cen",  32'(bus.Rom_sink_cen), 32'd1);
        @(negedge clock);
        verifica("t2_valida_baixa", 32'(bus.instr_valida), 32'd0);
        @(negedge clock);
        verifica("t2_valida_alta", 32'(bus.instr_valida), 32'd1);
        verifica("t2_livre", 32'(bus.ocupado), 32'd0);
        aguarda_fim("t2b");

        // 3: Z-conditional jump, both senses
        ciclo(0, 0, 4'hF, 0, 16'h0000, 5'h00, 4'b0100);
        ciclo(0, 0, 4'h2, 1, 16'h0040, 5'h1F, 4'h0);
        ciclo(1, 0, 4'hF, 0, 16'h0000, 5'h1F, 4'h0);
        aguarda_fim("t3a");
        verifica("t3_pc40", 32'(bus.pc_atual), 32'h0000_0040);
        ciclo(0, 0, 4'h2, 0, 16'h0080, 5'h1F, 4'h0);
        ciclo(1, 0, 4'hF, 0, 16'h0000, 5'h1F, 4'h0);
        aguarda_fim("t3b");
        verifica("t3_pc41", 32'(bus.pc_atual), 32'h0000_0041);

        // 4: link capture with unconditional jump, then wrap at 0xFFFF
        ciclo(0, 0, 4'h0, 0, 16'h0010, 5'h1F, 4'h0);
        ciclo(1, 0, 4'hF, 0, 16'h0000, 5'h1F, 4'h0);
        aguarda_fim("t4a");
        ciclo(0, 1, 4'hC, 0, 16'h0200, 5'h1F, 4'h0);
        verifica("t4_link", 32'(bus.pc_link), 32'h0000_0011);
        ciclo(1, 0, 4'hF, 0, 16'h0000, 5'h1F, 4'h0);
        aguarda_fim("t4b");
        verifica("t4_pc200", 32'(bus.pc_atual), 32'h0000_0200);
        ciclo(0, 0, 4'h0, 0, 16'hFFFF, 5'h1F, 4'h0);
        ciclo(1, 0, 4'hF, 0, 16'h0000, 5'h1F, 4'h0);
        aguarda_fim("t4c");
        ciclo(1, 0, 4'hF, 0, 16'h0000, 5'h1F, 4'h0);
        aguarda_fim("t4d");
        verifica("t4_wrap", 32'(bus.pc_atual), 32'h0000_0000);

        // 5: silent ROM forces one reissue, then answers 3 cycles after it
        atrasos.push_back(TIMEOUT); atrasos.push_back(2);
        ciclo(1, 0, 4'hF, 0, 16'h0000, 5'h1F, 4'h0);
        aguarda_fim("t5");
        verifica("t5_nreq2", 32'(n_req), 32'd2);

        // 6: overlapping strobe, then reset during ESPERA
        atrasos.push_back(5);
        ciclo(1, 0, 4'hF, 0, 16'h0000, 5'h1F, 4'h0);
        @(negedge clock);
        ciclo(1, 0, 4'hF, 0, 16'h0000, 5'h1F, 4'h0);
        verifica("t6_erro", 32'(bus.erro_sobreposicao), 32'd1);
        aguarda_fim("t6a");
        atrasos.push_back(6);
        ciclo(1, 0, 4'h0, 0, 16'h1234, 5'h1F, 4'h0);
        @(negedge clock);
        reset = 1'b1; modelo_reset();
        @(negedge clock);
        verifica("t6_rst_pc",     32'(bus.pc_atual), 32'(PC_INICIAL));
        verifica("t6_rst_erro",   32'(bus.erro_sobreposicao), 32'd0);
        verifica("t6_rst_valida", 32'(bus.instr_valida), 32'd0);
        reset = 1'b0; em_busca = 1'b1; n_req = 0; n_timeouts = 0;
        @(negedge clock);
        aguarda_fim("t6b");
        ciclo(1, 0, 4'hF, 0, 16'h0000, 5'h1F, 4'h0);
        aguarda_fim("t6c");

        // Randomized sequences against the model
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                r_upd = 5'($urandom_range(0, 31)); r_fin = 4'($urandom_range(0, 15));
                ciclo(0, 0, 4'hF, 0, 16'h0000, r_upd, r_fin);
            end
            r_cond = 4'($urandom_range(0, 15)); r_sent = 1'($urandom_range(0, 1));
            r_alvo = 16'($urandom); r_copia = 1'($urandom_range(0, 1));
            r_upd = 5'($urandom_range(0, 31)); r_fin = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) begin
                ciclo(1, r_copia, r_cond, r_sent, r_alvo, r_upd, r_fin);
            end else begin
                ciclo(0, r_copia, r_cond, r_sent, r_alvo, r_upd, r_fin);
                ciclo(1, 0, 4'hF, 0, 16'h0000, 5'h1F, 4'h0);
            end
            aguarda_fim("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/unidade_busca_pc.md
Name: unidade_busca_pc

Overview:
Program-counter and instruction-fetch stage directly upstream of the multicycle control FSM.
- Holds the PC, the flag register and the link (return-address) register.
- Evaluates jump conditions issued by control and applies any taken jump at the next PC advance.
- Runs a request/valid handshake with the instruction ROM and presents the latched instruction word to control.

Parameters:
LARG, 16, data/address width of PC, link register, target and instruction.
TIMEOUT, 8, cycles to wait for rom_valido before the read is reissued (≥2).
PC_INICIAL, 0, PC value loaded on reset.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
controlePC  in  1  one-cycle strobe: advance PC and fetch the next instruction.
controlePCcopia  in  1  strobe: load link register with PC+1.
condicaoJump  in  4  jump condition selector; 4'b1111 = no evaluation this cycle.
jump_ver_fal  in  1  sense for conditional codes: 1 = jump if condition true, 0 = jump if false.
salto_destino  in  LARG  absolute jump target, sampled with condicaoJump.
atualizaFlag  in  5  flag write enable; any value ≠ 5'b11111 writes flags.
flag_in  in  4  {N,Z,C,V} from the ALU.
rom_dado  in  LARG  ROM read data.
rom_valido  in  1  ROM data valid.
rom_addr  out  LARG  ROM read address (= PC).
Rom_sink_cen  out  1  ROM chip enable.
Rom_sink_ren  out  1  ROM read enable.
instrucao  out  LARG  latched instruction word.
instr_valida  out  1  instrucao holds the word at the current PC.
pc_atual  out  LARG  current PC.
pc_link  out  LARG  link register.
flags  out  4  registered {N,Z,C,V}.
ocupado  out  1  fetch FSM not in OCIOSO.
erro_sobreposicao  out  1  sticky: controlePC arrived while ocupado.

Behaviour:

Reset:
- pc_atual=PC_INICIAL; pc_link, flags, instrucao, salto_pendente, alvo, wait counter = 0.
- instr_valida, Rom_sink_cen, Rom_sink_ren, erro_sobreposicao = 0.
- FSM goes to REQ, so the word at PC_INICIAL is fetched automatically; ocupado=1 from the first cycle after reset.
- Reset mid-fetch aborts the fetch; any pending jump is discarded.

FSM states OCIOSO, REQ, ESPERA:
- OCIOSO, on controlePC:
  - pc_atual <= salto_pendente ? alvo : pc_atual+1, modulo 2^LARG (FFFF→0000).
  - Clear salto_pendente; go to REQ.
- REQ:
  - Rom_sink_cen=Rom_sink_ren=1 for exactly this cycle; rom_addr=pc_atual; instr_valida<=0; wait counter<=0.
  - Go to ESPERA.
- ESPERA:
  - If rom_valido: instrucao<=rom_dado, instr_valida<=1, go to OCIOSO. instr_valida is high from the next cycle.
  - Else, when the counter reaches TIMEOUT-1: go to REQ (retry, same address).
  - Otherwise increment the counter.
- rom_valido outside ESPERA is ignored.
- controlePC while ocupado: ignored, erro_sobreposicao<=1 (cleared only by reset).
- Fetch latency with a zero-wait ROM (rom_valido in the first ESPERA cycle): instr_valida is high 3 cycles after the controlePC edge.

Flags:
- flags <= flag_in when atualizaFlag ≠ 5'b11111.

Jump evaluation, in any cycle where condicaoJump ≠ 4'b1111, using the registered flags (pre-update value if a flag write happens in the same cycle):
- 0000 or 1100: always taken; jump_ver_fal is ignored.
- 0001 N, 0010 Z, 0011 C, 0100 V, 0101 N|Z, 0110 N^V: taken = (cond == jump_ver_fal).
- All other codes: not taken.
- Result: salto_pendente<=taken; alvo<=salto_destino.
- A later evaluation before controlePC overwrites the earlier one.
- controlePC in the same cycle as an evaluation uses the old salto_pendente; the new result is retained for the following advance.

Link register:
- controlePCcopia: pc_link <= pc_atual+1 (wraps).
- If it coincides with controlePC, it uses the pre-advance pc_atual.

Test Plan:
1. Reset release, ROM responds 2 cycles after request with 16'hA5A5 → one-cycle cen/ren at addr 0; instrucao=A5A5, instr_valida=1; pc_atual=0.
2. controlePC with no jump pending, pc=0x0003 → rom_addr=0x0004; instr_valida low during fetch; with a zero-wait ROM it returns high 3 cycles after controlePC.
3. flags: write Z=1, then condicaoJump=0010, jump_ver_fal=1, salto_destino=0x0040, then controlePC → fetch at 0x0040. Same with jump_ver_fal=0 → fetch at pc+1.
4. controlePCcopia at pc=0x0010 plus condicaoJump=1100, target 0x0200 → pc_link=0x0011; next fetch at 0x0200. pc=0xFFFF with no jump → next fetch at 0x0000.
5. ROM silent for TIMEOUT=8 cycles → request reissued at the same address on the 9th cycle after the first; rom_valido 3 cycles later latches data.
6. controlePC pulsed during ESPERA → ignored, PC unchanged, erro_sobreposicao=1. Reset asserted during ESPERA → PC=0 and automatic refetch of address 0.
